// File: rtl/bram_capture_controller_pkg.sv
// Shared definitions for the capture controller and its strobe generator.
//   cap_state_t : capture FSM state encoding
//   BYTE_LANES  : number of BRAM write-enable lanes (32-bit word)
//   ADDR_SHIFT  : word index to byte address shift
package bram_capture_controller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } cap_state_t;

  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned ADDR_SHIFT = 2;

endpackage

// File: rtl/capture_strobe_gen.sv
// Decimation strobe generator.
//   clk, rst : clock and synchronous active-high reset
//   clear    : synchronous clear; holds the counter at 0
//   period   : counter runs 0..period then wraps
//   strobe   : high while the counter is 0 (one cycle in every period+1)
module capture_strobe_gen #(
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    strobe
);

  logic [PERIOD_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt >= period) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PERIOD_WIDTH'(1);
    end
  end

  assign strobe = (cnt == '0);

endmodule

// File: rtl/bram_capture_controller.sv
// ADC-to-BRAM capture sequencer.
//   clk, rst      : ADC clock, synchronous active-high reset
//   arm, abort    : single-cycle control pulses from the register bank
//   trig          : trigger level; a rising edge starts an armed capture
//   length, decim : samples per capture and decimation period (latched on arm)
//   address, wen  : BRAM byte address and 4-lane write enable
//   busy, done    : status (ARMED/CAPTURE, DONE)
//   capture_count : completed captures, wraps modulo 2^32
module bram_capture_controller
  import bram_capture_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned DECIM_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig,
  input  logic [ADDR_WIDTH:0]    length,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic [31:0]            address,
  output logic [BYTE_LANES-1:0]  wen,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            capture_count
);

  localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  cap_state_t             state_q, state_d;
  logic                   trig_reg;
  logic [ADDR_WIDTH:0]    len_q, len_d;
  logic [DECIM_WIDTH-1:0] dec_q, dec_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic                   last_q, last_d;
  logic [31:0]            addr_d;
  logic [BYTE_LANES-1:0]  wen_d;
  logic                   busy_d, done_d;
  logic [31:0]            count_d;
  logic                   trig_edge;
  logic                   strobe;
  logic                   is_last;

  assign trig_edge = trig & ~trig_reg;
  assign is_last   = ({1'b0, idx_q} == (len_q - 1'b1));

  // Counter sits at 0 outside CAPTURE, so the first strobe lands on the
  // first CAPTURE cycle.
  capture_strobe_gen #(
    .PERIOD_WIDTH(DECIM_WIDTH)
  ) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != CAPTURE),
    .period (dec_q),
    .strobe (strobe)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dec_d   = dec_q;
    idx_d   = idx_q;
    last_d  = last_q;
    addr_d  = address;
    wen_d   = '0;
    count_d = capture_count;

    if (abort) begin
      state_d = IDLE;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ARMED: begin
          if (arm) begin
            state_d = ARMED;
            len_d   = ((length == '0) || (length > FULL_LEN)) ? FULL_LEN : length;
            dec_d   = decim;
            idx_d   = '0;
            last_d  = 1'b0;
          end else if ((state_q == ARMED) && trig_edge) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          // last_q marks that the final write went out on the previous
          // cycle; completing one cycle later keeps done/count aligned with
          // wen dropping and blocks a wrapped extra write.
          if (last_q) begin
            state_d = DONE;
            count_d = capture_count + 32'd1;
            last_d  = 1'b0;
          end else if (strobe) begin
            wen_d  = '1;
            addr_d = {{(32 - ADDR_WIDTH){1'b0}}, idx_q} << ADDR_SHIFT;
            idx_d  = idx_q + ADDR_WIDTH'(1);
            last_d = is_last;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == ARMED) || (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      trig_reg      <= 1'b1;
      len_q         <= '0;
      dec_q         <= '0;
      idx_q         <= '0;
      last_q        <= 1'b0;
      address       <= '0;
      wen           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      capture_count <= '0;
    end else begin
      state_q       <= state_d;
      trig_reg      <= trig;
      len_q         <= len_d;
      dec_q         <= dec_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      address       <= addr_d;
      wen           <= wen_d;
      busy          <= busy_d;
      done          <= done_d;
      capture_count <= count_d;
    end
  end

endmodule

// File: tb/tb_bram_capture_controller.sv
module tb_bram_capture_controller;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst, arm, abort, trig;
  logic [AW:0]   length;
  logic [DW-1:0] decim;
  logic [31:0]   address;
  logic [3:0]    wen;
  logic          busy, done;
  logic [31:0]   capture_count;

  bram_capture_controller #(
    .ADDR_WIDTH (AW),
    .DECIM_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .trig         (trig),
    .length       (length),
    .decim        (decim),
    .address      (address),
    .wen          (wen),
    .busy         (busy),
    .done         (done),
    .capture_count(capture_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wen !== 4'h0) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_wr", {28'h0, wen}, 32'h0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check_eq("wr_cycle", cyc, e.cyc);
        check_eq("wr_addr", address, e.addr);
        check_eq("wr_wen", {28'h0, wen}, 32'hF);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm_cfg(input int len, input int dec);
    length = (AW + 1)'(len);
    decim  = DW'(dec);
    arm    = 1'b1;
    tick(1);
    arm    = 1'b0;
  endtask

  // Low then high on trig; the rising edge is sampled on the next posedge
  // (cycle m+1), so write k is visible at cycle m+2+k*(dec+1).
  task automatic fire(input int dec, input int npush);
    int m;
    trig = 1'b0;
    tick(1);
    trig = 1'b1;
    m = cyc;
    for (int k = 0; k < npush; k++) begin
      wr_t e;
      e.cyc  = m + 2 + k * (dec + 1);
      e.addr = 32'(k * 4);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) tick(1);
    check_eq("done_reached", {31'h0, done}, 32'h1);
    check_eq("sb_empty", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b1;
    length = '0; decim = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_eq("rst_address", address, 32'h0);
    check_eq("rst_wen", {28'h0, wen}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_count", capture_count, 32'h0);

    // trig held high through reset and arm: no capture
    arm_cfg(4, 0);
    tick(10);
    check_eq("held_trig_busy", {31'h0, busy}, 32'h1);
    check_eq("held_trig_nowr", {28'h0, wen}, 32'h0);

    // basic capture after trig falls and rises
    fire(0, 4);
    wait_done(50);
    check_eq("basic_busy", {31'h0, busy}, 32'h0);
    check_eq("basic_count", capture_count, 32'h1);
    check_eq("basic_addr_hold", address, 32'hC);

    // edges in DONE are ignored
    trig = 1'b0; tick(2); trig = 1'b1; tick(6);
    check_eq("done_edge_done", {31'h0, done}, 32'h1);

    // arm from DONE, config changed after arm, second edge mid-capture
    trig = 1'b0;
    arm_cfg(3, 2);
    check_eq("rearm_done_clr", {31'h0, done}, 32'h0);
    check_eq("rearm_busy", {31'h0, busy}, 32'h1);
    length = 14'd7; decim = 16'd0;
    fire(2, 3);
    tick(3); trig = 1'b0; tick(1); trig = 1'b1;
    wait_done(60);
    check_eq("decim_count", capture_count, 32'h2);
    check_eq("decim_addr_hold", address, 32'h8);

    // abort while write index 1 is visible: nothing further is written
    arm_cfg(10, 0);
    fire(0, 2);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_eq("abort_wen", {28'h0, wen}, 32'h0);
    check_eq("abort_busy", {31'h0, busy}, 32'h0);
    check_eq("abort_done", {31'h0, done}, 32'h0);
    check_eq("abort_count", capture_count, 32'h2);
    // edge in IDLE is ignored
    trig = 1'b0; tick(1); trig = 1'b1; tick(8);
    check_eq("idle_edge_busy", {31'h0, busy}, 32'h0);
    check_eq("abort_sb_empty", sb.size(), 0);

    // reset mid-capture
    arm_cfg(10, 0);
    fire(0, 3);
    tick(4);
    rst = 1'b1;
    tick(1);
    check_eq("mrst_wen", {28'h0, wen}, 32'h0);
    check_eq("mrst_address", address, 32'h0);
    check_eq("mrst_busy", {31'h0, busy}, 32'h0);
    check_eq("mrst_done", {31'h0, done}, 32'h0);
    check_eq("mrst_count", capture_count, 32'h0);
    rst = 1'b0;
    tick(2);
    check_eq("mrst_sb_empty", sb.size(), 0);

    // arm and edge together in ARMED: arm wins (re-latches length=0)
    arm_cfg(5, 3);
    trig = 1'b0; tick(1);
    trig = 1'b1; arm = 1'b1; length = '0; decim = '0;
    tick(1);
    arm = 1'b0;
    tick(6);
    check_eq("arm_edge_busy", {31'h0, busy}, 32'h1);
    check_eq("arm_edge_nowr", {28'h0, wen}, 32'h0);

    // full depth via clamp of length=0
    fire(0, 8192);
    wait_done(9000);
    check_eq("full_addr", address, 32'h7FFC);
    check_eq("full_count", capture_count, 32'h1);
    tick(6);
    check_eq("full_no_wrap_wen", {28'h0, wen}, 32'h0);
    check_eq("full_done_hold", {31'h0, done}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
